rem_line_packer: RTL



---
 rtl/rem_line_packer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rem_line_packer.sv
// rtl/rem_line_packer.sv - packs commands and a byte stream into 512-bit matcher lines
// Optional feature macro: REM_PACK_LENCHK_EN (byte_last length checking, err_len reporting).
module rem_line_packer #(
    parameter logic [7:0] PAD_CHAR   = 8'h00,
    parameter int         LINE_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_is_conf,
    input  logic [511:0]              cmd_config,
    input  logic [15:0]               cmd_length,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    input  logic [7:0]                byte_data,
    input  logic                      byte_last,
    output logic                      out_valid,
    output logic [LINE_BYTES*8-1:0]   out_data,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err_len
);

    localparam int LW = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        EMIT,
        EMIT_LAST,
        DRAIN
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_line;
    logic [5:0]      r_ptr;
    logic [15:0]     r_rem;
    logic            r_err;
    logic [LW-1:0]   w_pad_line;

    assign w_pad_line = {LINE_BYTES{PAD_CHAR}};

`ifdef REM_PACK_LENCHK_EN
    // Set when the commanded length ran out before byte_last; the tail is drained after the final line.
    logic            r_drain;
`else
    logic            w_unused;
    assign w_unused = byte_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
`ifdef REM_PACK_LENCHK_EN
            r_drain <= 1'b0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_is_conf) begin
                            r_line  <= cmd_config;
                            r_state <= EMIT_LAST;
                        end else if (cmd_length == 16'd0) begin
                            r_line  <= {w_pad_line[LW-1:16], 16'h0000};
                            r_state <= EMIT_LAST;
                        end else begin
                            // Header counts itself so the matcher's line count equals lines emitted.
                            r_line  <= {w_pad_line[LW-1:16], cmd_length + 16'd2};
                            r_ptr   <= 6'd2;
                            r_rem   <= cmd_length;
                            r_state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (byte_valid) begin
                        r_line[{r_ptr, 3'b000} +: 8] <= byte_data;
                        r_ptr <= r_ptr + 6'd1;
                        r_rem <= r_rem - 16'd1;
`ifdef REM_PACK_LENCHK_EN
                        if (byte_last && r_rem != 16'd1) begin
                            r_state <= EMIT_LAST;
                            r_err   <= 1'b1;
                        end else if (r_rem == 16'd1) begin
                            r_state <= EMIT_LAST;
                            r_drain <= !byte_last;
                        end else if (r_ptr == 6'd63) begin
                            r_state <= EMIT;
                        end
`else
                        if (r_rem == 16'd1) begin
                            r_state <= EMIT_LAST;
                        end else if (r_ptr == 6'd63) begin
                            r_state <= EMIT;
                        end
`endif
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_line  <= w_pad_line;
                        r_ptr   <= 6'd0;
                        r_state <= FILL;
                    end
                end
                EMIT_LAST: begin
                    if (out_ready) begin
`ifdef REM_PACK_LENCHK_EN
                        r_state <= r_drain ? DRAIN : IDLE;
                        r_drain <= 1'b0;
`else
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef REM_PACK_LENCHK_EN
                DRAIN: begin
                    if (byte_valid && byte_last) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = rst && (r_state == IDLE);
`ifdef REM_PACK_LENCHK_EN
    assign byte_ready = rst && (r_state == FILL || r_state == DRAIN);
`else
    assign byte_ready = rst && (r_state == FILL);
`endif
    assign out_valid  = rst && (r_state == EMIT || r_state == EMIT_LAST);
    assign out_data   = r_line;
    assign busy       = (r_state != IDLE);
    assign err_len    = r_err;

endmodule
